// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown display path.
//  state_t    : display FSM encoding (IDLE/RUN/EXPIRED/HOLD)
//  SEG_*      : active-low 7-segment glyphs, bit order {g,f,e,d,c,b,a}
package countdown_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SEG_W   = 7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;

    localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

endpackage

// File: rtl/countdown_hex_display_if.sv
// Timer-to-display interface.
//  enable, digit_in, expire : driven by the countdown timer (master)
//  hex1_n, hex0_n, blink_done : driven by the display block (slave)
interface countdown_hex_display_if;
    import countdown_pkg::*;

    logic               enable;
    logic [DIGIT_W-1:0] digit_in;
    logic               expire;
    logic [SEG_W-1:0]   hex1_n;
    logic [SEG_W-1:0]   hex0_n;
    logic               blink_done;

    modport master (
        output enable, digit_in, expire,
        input  hex1_n, hex0_n, blink_done
    );

    modport slave (
        input  enable, digit_in, expire,
        output hex1_n, hex0_n, blink_done
    );

endinterface

// File: rtl/countdown_hex_display_seg7_encode.sv
// Combinational 4-bit to active-low 7-segment decoder.
//  code  : value to show; 0..9 give digits, anything above gives a dash
//  seg_c : active-low segments {g,f,e,d,c,b,a}
module seg7_encode
    import countdown_pkg::*;
(
    input  logic [DIGIT_W-1:0] code,
    output logic [SEG_W-1:0]   seg_c
);

    always_comb begin
        seg_c = SEG_DASH;
        if (code <= DIGIT_W'(9)) begin
            seg_c = SEG_DIGIT[code];
        end
    end

endmodule

// File: rtl/countdown_hex_display.sv
// Drives two HEX displays from the countdown value; blinks "00" on expiry,
// pulses blink_done at the end of the blink sequence, then holds "00".
//  clk, rst : system clock, synchronous active-high reset
//  bus      : timer interface (slave side), see countdown_hex_display_if
module countdown_hex_display
    import countdown_pkg::*;
#(
    parameter int unsigned BLINK_HALF    = 12_500_000,
    parameter int unsigned BLINK_TOGGLES = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    countdown_hex_display_if.slave  bus
);

    localparam int unsigned HALF_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int unsigned TOG_W  = $clog2(BLINK_TOGGLES + 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(BLINK_HALF - 1);
    localparam logic [TOG_W-1:0]  TOG_LAST  = TOG_W'(BLINK_TOGGLES - 1);

    state_t             state;
    logic [HALF_W-1:0]  half_cnt;
    logic [TOG_W-1:0]   tog_cnt;
    logic [SEG_W-1:0]   hex1_q;
    logic [SEG_W-1:0]   hex0_q;
    logic               done_q;

    logic [DIGIT_W-1:0] tens_code;
    logic [DIGIT_W-1:0] units_code;
    logic [SEG_W-1:0]   tens_seg;
    logic [SEG_W-1:0]   units_seg;

    // Split the live value into per-display codes; 11..15 pass through so both decode to dash.
    always_comb begin
        tens_code  = 4'hF;
        units_code = bus.digit_in;
        if (bus.digit_in == DIGIT_W'(10)) begin
            tens_code  = DIGIT_W'(1);
            units_code = DIGIT_W'(0);
        end
    end

    seg7_encode u_tens  (.code(tens_code),  .seg_c(tens_seg));
    seg7_encode u_units (.code(units_code), .seg_c(units_seg));

    // FSM, blink counters and output registers; dropping enable wins over everything but reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            half_cnt <= '0;
            tog_cnt  <= '0;
            hex1_q   <= SEG_BLANK;
            hex0_q   <= SEG_BLANK;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!bus.enable) begin
                state  <= ST_IDLE;
                hex1_q <= SEG_BLANK;
                hex0_q <= SEG_BLANK;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state  <= ST_RUN;
                        hex1_q <= SEG_BLANK;
                        hex0_q <= SEG_BLANK;
                    end
                    ST_RUN: begin
                        hex1_q <= (bus.digit_in < DIGIT_W'(10)) ? SEG_BLANK : tens_seg;
                        hex0_q <= units_seg;
                        if (bus.expire) begin
                            state    <= ST_EXPIRED;
                            half_cnt <= '0;
                            tog_cnt  <= '0;
                        end
                    end
                    ST_EXPIRED: begin
                        // Even half-periods are the OFF phase, odd ones show "00".
                        hex1_q <= tog_cnt[0] ? SEG_DIGIT[0] : SEG_BLANK;
                        hex0_q <= tog_cnt[0] ? SEG_DIGIT[0] : SEG_BLANK;
                        if (half_cnt == HALF_LAST) begin
                            half_cnt <= '0;
                            if (tog_cnt == TOG_LAST) begin
                                done_q <= 1'b1;
                                state  <= ST_HOLD;
                            end else begin
                                tog_cnt <= tog_cnt + TOG_W'(1);
                            end
                        end else begin
                            half_cnt <= half_cnt + HALF_W'(1);
                        end
                    end
                    ST_HOLD: begin
                        hex1_q <= SEG_DIGIT[0];
                        hex0_q <= SEG_DIGIT[0];
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.hex1_n     = hex1_q;
    assign bus.hex0_n     = hex0_q;
    assign bus.blink_done = done_q;

endmodule

// File: tb/tb_countdown_hex_display.sv
// Self-checking bench for countdown_hex_display with a short blink period.
module tb_countdown_hex_display;

    localparam int HALF = 4;
    localparam int TOG  = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    countdown_hex_display_if bus();

    countdown_hex_display #(
        .BLINK_HALF    (HALF),
        .BLINK_TOGGLES (TOG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [6:0] glyph [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Behavioural model: display mode plus cycles elapsed since expiry.
    localparam int M_IDLE = 0, M_RUN = 1, M_EXP = 2, M_HOLD = 3;
    int         mode    = M_IDLE;
    int         elapsed = 0;
    logic [6:0] m_h1    = 7'h7F;
    logic [6:0] m_h0    = 7'h7F;
    logic       m_done  = 1'b0;

    always @(posedge clk) begin
        m_done = 1'b0;
        if (rst) begin
            mode = M_IDLE; m_h1 = 7'h7F; m_h0 = 7'h7F;
        end else if (!bus.enable) begin
            mode = M_IDLE; m_h1 = 7'h7F; m_h0 = 7'h7F;
        end else begin
            case (mode)
                M_IDLE: begin
                    mode = M_RUN; m_h1 = 7'h7F; m_h0 = 7'h7F;
                end
                M_RUN: begin
                    if (int'(bus.digit_in) <= 9) begin
                        m_h1 = 7'h7F; m_h0 = glyph[int'(bus.digit_in)];
                    end else if (int'(bus.digit_in) == 10) begin
                        m_h1 = glyph[1]; m_h0 = glyph[0];
                    end else begin
                        m_h1 = 7'h3F; m_h0 = 7'h3F;
                    end
                    if (bus.expire) begin
                        mode = M_EXP; elapsed = 0;
                    end
                end
                M_EXP: begin
                    if (((elapsed / HALF) % 2) == 1) begin
                        m_h1 = glyph[0]; m_h0 = glyph[0];
                    end else begin
                        m_h1 = 7'h7F; m_h0 = 7'h7F;
                    end
                    if (elapsed == HALF * TOG - 1) begin
                        m_done = 1'b1; mode = M_HOLD;
                    end
                    elapsed++;
                end
                default: begin
                    m_h1 = glyph[0]; m_h0 = glyph[0];
                end
            endcase
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("model_hex1", int'(bus.hex1_n), int'(m_h1));
        chk("model_hex0", int'(bus.hex0_n), int'(m_h0));
        chk("model_done", int'(bus.blink_done), int'(m_done));
    end

    // Literal expectation applied to both the DUT and the model.
    task automatic lit(input string name, input int h1, input int h0, input int d);
        chk({name, "_hex1"}, int'(bus.hex1_n), h1);
        chk({name, "_hex0"}, int'(bus.hex0_n), h0);
        chk({name, "_done"}, int'(bus.blink_done), d);
        chk({name, "_mdl"},  int'({m_h1, m_h0, m_done}), (h1 << 8) | (h0 << 1) | d);
    endtask

    task automatic drive(input logic e, input logic [3:0] d, input logic x);
        bus.enable   = e;
        bus.digit_in = d;
        bus.expire   = x;
        @(negedge clk);
    endtask

    // Expire from RUN, then run the blink; optionally inject extra expires or drop enable at step drop_k.
    task automatic blink_seq(input bit extra, input int drop_k);
        int  done_cnt;
        int  done_at;
        logic e;
        logic x;
        done_cnt = 0;
        done_at  = -1;
        drive(1'b1, 4'd5, 1'b1);
        lit("pre_blink", 'h7F, 'h12, 0);
        for (int k = 1; k <= 32; k++) begin
            x = extra && (k == 3 || k == 10 || k == 24 || k == 27);
            e = (k != drop_k);
            drive(e, (k > 26) ? 4'd12 : 4'd5, x);
            if (bus.blink_done) begin
                done_cnt++;
                done_at = k;
            end
            if (!e) begin
                lit("drop", 'h7F, 'h7F, 0);
                chk("drop_no_done", done_cnt, 0);
                return;
            end
            if (k == 1)  lit("blink_k1",  'h7F, 'h7F, 0);
            if (k == 4)  lit("blink_k4",  'h7F, 'h7F, 0);
            if (k == 5)  lit("blink_k5",  'h40, 'h40, 0);
            if (k == 8)  lit("blink_k8",  'h40, 'h40, 0);
            if (k == 9)  lit("blink_k9",  'h7F, 'h7F, 0);
            if (k == 24) lit("blink_k24", 'h40, 'h40, 1);
            if (k == 25) lit("hold_k25",  'h40, 'h40, 0);
            if (k == 32) lit("hold_k32",  'h40, 'h40, 0);
        end
        chk("done_count", done_cnt, 1);
        chk("done_cycle", done_at, 24);
    endtask

    // Leave via IDLE and come back to RUN; the expire seen in IDLE must be ignored.
    task automatic rerun();
        drive(1'b0, 4'd5, 1'b0);
        lit("rerun_idle", 'h7F, 'h7F, 0);
        drive(1'b1, 4'd5, 1'b1);
        lit("rerun_entry", 'h7F, 'h7F, 0);
        drive(1'b1, 4'd5, 1'b0);
        lit("rerun_run", 'h7F, 'h12, 0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) begin
            drive(1'b1, 4'd0, 1'b0);
            lit("reset", 'h7F, 'h7F, 0);
        end
        rst = 1'b0;

        drive(1'b1, 4'd10, 1'b0); lit("idle_to_run", 'h7F, 'h7F, 0);
        drive(1'b1, 4'd10, 1'b0); lit("run_10", 'h79, 'h40, 0);
        drive(1'b1, 4'd7,  1'b0); lit("run_7",  'h7F, 'h78, 0);
        drive(1'b1, 4'd0,  1'b0); lit("run_0",  'h7F, 'h40, 0);
        drive(1'b1, 4'd12, 1'b0); lit("run_12", 'h3F, 'h3F, 0);
        drive(1'b1, 4'd9,  1'b0); lit("run_9",  'h7F, 'h10, 0);
        drive(1'b1, 4'd5,  1'b0); lit("run_5",  'h7F, 'h12, 0);

        blink_seq(1'b0, 0);
        rerun();
        blink_seq(1'b1, 0);
        rerun();
        blink_seq(1'b0, 10);
        drive(1'b1, 4'd5, 1'b0);
        drive(1'b1, 4'd5, 1'b0);
        lit("after_drop_run", 'h7F, 'h12, 0);
        blink_seq(1'b0, 24);

        drive(1'b1, 4'd3, 1'b0); lit("reenable_entry", 'h7F, 'h7F, 0);
        drive(1'b1, 4'd3, 1'b0); lit("reenable_3", 'h7F, 'h30, 0);
        drive(1'b1, 4'd10, 1'b0); lit("reenable_10", 'h79, 'h40, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
